// File: rtl/fpaddsub_pkg.sv
// Shared constants and types for the two-requester FP add/sub scheduler.
package fpaddsub_pkg;

  localparam int FP_W = 32;

  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RZ  = 2'd1;
  localparam logic [1:0] RUP = 2'd2;
  localparam logic [1:0] RDN = 2'd3;

  typedef logic req_id_t;

endpackage

// File: rtl/fpaddsub_rsp_fifo.sv
// Per-requester response FIFO; read data is forced to zero while empty.
module fpaddsub_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         not_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_rd;

  assign not_empty = (count_q != '0);
  assign do_rd     = rd_en && not_empty;
  assign rd_data   = not_empty ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !do_rd) count_d = count_q + CW'(1);
    else if (!wr_en && do_rd) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: rd_data is masked until an entry is written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fpaddsub_sched.sv
// Credit-based round-robin scheduler sharing one pipelined FP add/sub unit
// between two requesters. Optional counters: FPADDSUB_SCHED_STATS_EN.
module fpaddsub_sched
  import fpaddsub_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int CREDITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [63:0]     req_a,
  input  logic [63:0]     req_b,
  input  logic [1:0]      req_sub,
  input  logic [3:0]      req_rmode,
  output logic            dp_valid,
  output logic [FP_W-1:0] dp_a,
  output logic [FP_W-1:0] dp_b,
  output logic            dp_sub,
  output logic [1:0]      dp_rmode,
  input  logic [FP_W-1:0] dp_z,
  input  logic            dp_inexact,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [63:0]     rsp_z,
  output logic [1:0]      rsp_inexact
`ifdef FPADDSUB_SCHED_STATS_EN
  ,
  output logic [31:0]     stat_issued,
  output logic [31:0]     stat_inexact
`endif
);

  localparam int CW = $clog2(CREDITS) + 1;

  logic [1:0][CW-1:0]   credit_q, credit_d;
  logic                 ptr_q, ptr_d;
  logic [1:0]           elig, grant, rsp_hs, fifo_wr;
  req_id_t              gnt_id;

  logic                 dp_valid_q, dp_valid_d;
  logic [FP_W-1:0]      dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  logic                 dp_sub_q, dp_sub_d;
  logic [1:0]           dp_rmode_q, dp_rmode_d;
  req_id_t              dp_id_q, dp_id_d;

  logic [LATENCY-1:0]   tag_vld_q, tag_vld_d;
  req_id_t [LATENCY-1:0] tag_id_q, tag_id_d;

  logic [1:0][FP_W:0]   fifo_rd;

  // Arbitration: the pointer only matters when both requesters are eligible.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i]   = req_valid[i] && (credit_q[i] != '0);
      rsp_hs[i] = rsp_valid[i] && rsp_ready[i];
    end
    grant = elig;
    if (elig == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    gnt_id = grant[1];
  end

  assign req_ready = grant & {2{~rst}};

  always_comb begin
    dp_valid_d = |grant;
    dp_a_d     = dp_a_q;
    dp_b_d     = dp_b_q;
    dp_sub_d   = dp_sub_q;
    dp_rmode_d = dp_rmode_q;
    dp_id_d    = dp_id_q;
    ptr_d      = ptr_q;
    if (|grant) begin
      dp_a_d     = gnt_id ? req_a[63:32] : req_a[31:0];
      dp_b_d     = gnt_id ? req_b[63:32] : req_b[31:0];
      dp_sub_d   = req_sub[gnt_id];
      dp_rmode_d = gnt_id ? req_rmode[3:2] : req_rmode[1:0];
      dp_id_d    = gnt_id;
      ptr_d      = ~gnt_id;
    end
  end

  // Tag stage 0 follows the issue register, so the last stage lines up with dp_z.
  always_comb begin
    tag_vld_d[0] = dp_valid_q;
    tag_id_d[0]  = dp_id_q;
    for (int k = 1; k < LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
    for (int i = 0; i < 2; i++) begin
      fifo_wr[i]  = tag_vld_q[LATENCY-1] && (tag_id_q[LATENCY-1] == req_id_t'(i));
      credit_d[i] = credit_q[i];
      if (grant[i] && !rsp_hs[i]) credit_d[i] = credit_q[i] - CW'(1);
      else if (!grant[i] && rsp_hs[i]) credit_d[i] = credit_q[i] + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      credit_q   <= {2{CW'(CREDITS)}};
      dp_valid_q <= 1'b0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      dp_sub_q   <= 1'b0;
      dp_rmode_q <= '0;
      tag_vld_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      credit_q   <= credit_d;
      dp_valid_q <= dp_valid_d;
      dp_a_q     <= dp_a_d;
      dp_b_q     <= dp_b_d;
      dp_sub_q   <= dp_sub_d;
      dp_rmode_q <= dp_rmode_d;
      tag_vld_q  <= tag_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    dp_id_q  <= dp_id_d;
    tag_id_q <= tag_id_d;
  end

  assign dp_valid = dp_valid_q;
  assign dp_a     = dp_a_q;
  assign dp_b     = dp_b_q;
  assign dp_sub   = dp_sub_q;
  assign dp_rmode = dp_rmode_q;

  for (genvar g = 0; g < 2; g++) begin : g_rsp
    fpaddsub_rsp_fifo #(
      .DEPTH (CREDITS),
      .W     (FP_W + 1)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (fifo_wr[g]),
      .wr_data   ({dp_inexact, dp_z}),
      .rd_en     (rsp_hs[g]),
      .rd_data   (fifo_rd[g]),
      .not_empty (rsp_valid[g])
    );
    assign rsp_z[g*FP_W +: FP_W] = fifo_rd[g][FP_W-1:0];
    assign rsp_inexact[g]        = fifo_rd[g][FP_W];
  end

`ifdef FPADDSUB_SCHED_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_inexact_q, stat_inexact_d;

  always_comb begin
    stat_issued_d  = stat_issued_q + 32'(dp_valid_q);
    stat_inexact_d = stat_inexact_q + 32'((|fifo_wr) && dp_inexact);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_q  <= '0;
      stat_inexact_q <= '0;
    end else begin
      stat_issued_q  <= stat_issued_d;
      stat_inexact_q <= stat_inexact_d;
    end
  end

  assign stat_issued  = stat_issued_q;
  assign stat_inexact = stat_inexact_q;
`endif

endmodule

// File: tb/tb_fpaddsub_sched.sv
// Directed bench for fpaddsub_sched with a behavioural fixed-latency datapath.
module tb_fpaddsub_sched;

  localparam int LAT  = 4;
  localparam int CRED = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [1:0]  req_sub = '0;
  logic [3:0]  req_rmode = '0;
  logic        dp_valid;
  logic [31:0] dp_a, dp_b;
  logic        dp_sub;
  logic [1:0]  dp_rmode;
  logic [31:0] dp_z;
  logic        dp_inexact;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [63:0] rsp_z;
  logic [1:0]  rsp_inexact;
`ifdef FPADDSUB_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_inexact;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [32:0] expq [2][$];

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [1:0]  rm;
    logic [31:0] z;
    logic        inex;
  } vec_t;
  vec_t vt [5];

  always #5 clk = ~clk;

  fpaddsub_sched #(.LATENCY(LAT), .CREDITS(CRED)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_rmode(req_rmode),
    .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .dp_rmode(dp_rmode),
    .dp_z(dp_z), .dp_inexact(dp_inexact),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_inexact(rsp_inexact)
`ifdef FPADDSUB_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_inexact(stat_inexact)
`endif
  );

  // Stand-in datapath: 1.0+2.0 gives 3.0, everything else a cheap mix.
  function automatic logic [32:0] dpm(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !s) return {1'b0, 32'h4040_0000};
    return {b[0], a ^ b ^ {31'd0, s}};
  endfunction

  logic [LAT-1:0] pv = '0;
  logic [32:0]    pd [LAT];
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], dp_valid};
    pd[0] <= dpm(dp_a, dp_b, dp_sub);
    for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
  end
  // Idle cycles carry junk so a write without a valid tag is visible.
  assign dp_z       = pv[LAT-1] ? pd[LAT-1][31:0] : 32'hDEAD_BEEF;
  assign dp_inexact = pv[LAT-1] ? pd[LAT-1][32]   : 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [32:0] e;
    if (rst) return;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i])
        expq[i].push_back(dpm(req_a[32*i +: 32], req_b[32*i +: 32], req_sub[i]));
      if (rsp_valid[i] && rsp_ready[i]) begin
        if (expq[i].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp%0d_unexpected: got 0x%0h, expected no response", i, rsp_z[32*i +: 32]);
        end else begin
          e = expq[i].pop_front();
          chk($sformatf("rsp%0d_data", i), 64'({rsp_inexact[i], rsp_z[32*i +: 32]}), 64'(e));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [1:0] rm);
    req_valid[p]         = v;
    req_a[32*p +: 32]    = a;
    req_b[32*p +: 32]    = b;
    req_sub[p]           = s;
    req_rmode[2*p +: 2]  = rm;
  endtask

  initial begin
    int lat, cnt0, cnt1, hits;
    vt[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 2'd0, 32'h4040_0000, 1'b0};
    vt[1] = '{1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 2'd1, 32'h7F80_0001, 1'b0};
    vt[2] = '{0, 32'h1234_5678, 32'h0000_FFFF, 1'b0, 2'd2, 32'h1234_A987, 1'b1};
    vt[3] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 2'd3, 32'hFFFF_FFFF, 1'b1};
    vt[4] = '{1, 32'h0000_0000, 32'h8000_0000, 1'b0, 2'd0, 32'h8000_0000, 1'b0};

    // Reset state, before any clock edge
    #1 rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_dp_valid", 64'(dp_valid), 64'd0);
    chk("rst_dp_fields", 64'({dp_a, dp_b, dp_sub, dp_rmode} != '0), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_z", rsp_z, 64'd0);
    chk("rst_credit0", 64'(dut.credit_q[0]), 64'(CRED));
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;

    // Single ops, one per vector
    rsp_ready = 2'b11;
    for (int v = 0; v < 5; v++) begin
      drive(vt[v].port, 1'b1, vt[v].a, vt[v].b, vt[v].sub, vt[v].rm);
      #1;
      chk("vec_ready", 64'(req_ready), 64'(2'b01 << vt[v].port));
      tick();
      req_valid = '0;
      chk("vec_dp_valid", 64'(dp_valid), 64'd1);
      chk("vec_dp_ab", {dp_a, dp_b}, {vt[v].a, vt[v].b});
      chk("vec_dp_op", 64'({dp_sub, dp_rmode}), 64'({vt[v].sub, vt[v].rm}));
      lat = 1;
      while (!rsp_valid[vt[v].port] && lat < 30) begin
        tick();
        lat++;
      end
      chk("vec_latency", 64'(lat), 64'(LAT + 2));
      chk("vec_z", 64'(rsp_z[32*vt[v].port +: 32]), 64'(vt[v].z));
      chk("vec_inexact", 64'(rsp_inexact[vt[v].port]), 64'(vt[v].inex));
      tick();
      if (v == 0) chk("credit_restore", 64'(dut.credit_q[0]), 64'(CRED));
    end

    // Both ports saturated: strict alternation starting at port 0
    for (int k = 0; k < 12; k++) begin
      drive(0, 1'b1, 32'(32'h1000 + k), 32'(32'h5 + k), k[0], 2'(k));
      drive(1, 1'b1, 32'(32'h2000 + k), 32'(32'hA0 + k), ~k[0], 2'd3);
      #1;
      chk($sformatf("alt_grant%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      chk("alt_dp_valid", 64'(dp_valid), 64'd1);
    end
    req_valid = '0;
    repeat (12) tick();
    chk("alt_drain0", 64'(expq[0].size()), 64'd0);
    chk("alt_drain1", 64'(expq[1].size()), 64'd0);

    // Port 0 blocked on responses: credit caps acceptance at four
    rsp_ready = 2'b10;
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 12; k++) begin
      drive(0, 1'b1, 32'(32'h3000 + cnt0), 32'h0000_0007, 1'b0, 2'd1);
      drive(1, 1'b1, 32'(32'h3100 + cnt1), 32'h0000_0010, 1'b1, 2'd2);
      #1;
      if (req_ready[0]) cnt0++;
      if (req_ready[1]) cnt1++;
      tick();
    end
    #1;
    chk("cap_accepts0", 64'(cnt0), 64'd4);
    chk("cap_ready0_low", 64'(req_ready[0]), 64'd0);
    chk("cap_port1_served", 64'(cnt1 >= 4), 64'd1);
    req_valid = '0;
    rsp_ready = 2'b11;
    repeat (16) tick();
    chk("cap_drain0", 64'(expq[0].size()), 64'd0);
    chk("cap_drain1", 64'(expq[1].size()), 64'd0);

    // Accept and response handshake together at credit 1
    rsp_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 32'(32'h4000 + k), 32'(32'h20 + k), 1'b0, 2'd1);
      tick();
    end
    req_valid = '0;
    chk("c1_credit", 64'(dut.credit_q[0]), 64'd1);
    repeat (8) tick();
    chk("c1_rsp_valid", 64'(rsp_valid[0]), 64'd1);
    drive(0, 1'b1, 32'h4100_0000, 32'h0000_0003, 1'b1, 2'd2);
    rsp_ready = 2'b01;
    #1;
    chk("c1_ready", 64'(req_ready[0]), 64'd1);
    tick();
    chk("c1_credit_hold", 64'(dut.credit_q[0]), 64'd1);
    req_valid = '0;
    rsp_ready = 2'b11;
    repeat (14) tick();
    chk("c1_drain", 64'(expq[0].size()), 64'd0);
    chk("c1_credit_full", 64'(dut.credit_q[0]), 64'(CRED));

    // Reset with three ops in flight
    for (int k = 0; k < 3; k++) begin
      req_valid = '0;
      drive(k % 2, 1'b1, 32'(32'h7000 + k), 32'h0000_0001, 1'b0, 2'd0);
      tick();
    end
    req_valid = 2'b11;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_dp_valid", 64'(dp_valid), 64'd0);
    chk("mid_rst_dp_fields", 64'({dp_a, dp_b, dp_sub, dp_rmode} != '0), 64'd0);
    chk("mid_rst_rsp", 64'({rsp_valid, rsp_inexact}), 64'd0);
    chk("mid_rst_rsp_z", rsp_z, 64'd0);
    chk("mid_rst_credits", 64'({dut.credit_q[1], dut.credit_q[0]}), 64'({3'(CRED), 3'(CRED)}));
    expq[0].delete();
    expq[1].delete();
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;
    hits = 0;
    repeat (12) begin
      tick();
      if (rsp_valid != 2'b00) hits++;
    end
    chk("post_rst_no_rsp", 64'(hits), 64'd0);

`ifdef FPADDSUB_SCHED_STATS_EN
    // Ten issues, three of them flagged inexact (b odd)
    for (int k = 0; k < 10; k++) begin
      req_valid = '0;
      drive(k % 2, 1'b1, 32'(32'h5000 + k), 32'(32'h600 + ((k % 3) == 1)), 1'b0, 2'd0);
      tick();
    end
    req_valid = '0;
    repeat (14) tick();
    chk("stat_issued", 64'(stat_issued), 64'd10);
    chk("stat_inexact", 64'(stat_inexact), 64'd3);
`endif

    chk("final_q0", 64'(expq[0].size()), 64'd0);
    chk("final_q1", 64'(expq[1].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
